rmii_phy_endpoint: RTL

- PHY-side RMII endpoint: the far end of the MAC RMII interface, for SoC loopback, FPGA bring-up and simulation.
- Decode path: deserialises MAC rmii_txen/rmii_txd frames (preamble/SFD stripped) into a byte stream.
- Encode path: serialises a byte stream into rmii_crsdv/rmii_rxd frames with preamble, SFD and inter-frame gap.
- Full duplex. No CRC generation or checking; CRC bytes pass through as payload.

---
 rtl/rmii_phy_endpoint_if.sv | 31 +++
 rtl/rmii_phy_endpoint.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rmii_phy_endpoint_if.sv
// Bundle of the RMII pins, decoded/encoded byte streams and frame counters of
// the PHY-side RMII endpoint. master = MAC/stream environment, slave = endpoint.
interface rmii_phy_endpoint_if;
  logic        rmii_txen;
  logic [1:0]  rmii_txd;
  logic        rmii_crsdv;
  logic [1:0]  rmii_rxd;
  logic        m_valid;
  logic [7:0]  m_data;
  logic        m_last;
  logic        m_err;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_last;
  logic        s_ready;
  logic        underrun;
  logic [15:0] dec_frames;
  logic [15:0] enc_frames;

  modport master (
    output rmii_txen, rmii_txd, s_valid, s_data, s_last,
    input  rmii_crsdv, rmii_rxd, m_valid, m_data, m_last, m_err,
    input  s_ready, underrun, dec_frames, enc_frames
  );

  modport slave (
    input  rmii_txen, rmii_txd, s_valid, s_data, s_last,
    output rmii_crsdv, rmii_rxd, m_valid, m_data, m_last, m_err,
    output s_ready, underrun, dec_frames, enc_frames
  );
endinterface

// File: rtl/rmii_phy_endpoint.sv
// PHY-side RMII endpoint: decodes MAC txen/txd frames into bytes and encodes a
// byte stream into crsdv/rxd frames with preamble, SFD and inter-frame gap.
module rmii_phy_endpoint #(
  parameter int PREAMBLE_BYTES = 7,
  parameter int IFG_CYCLES     = 48
) (
  input logic                 rmii_refclk,
  input logic                 rstn,
  rmii_phy_endpoint_if.slave  bus
);
  localparam logic [7:0] SFD_IDX  = 8'(PREAMBLE_BYTES * 4 + 3);
  localparam logic [7:0] IFG_LAST = 8'(IFG_CYCLES - 1);

  // ---------------- decoder ----------------
  typedef enum logic [1:0] {D_IDLE, D_PRE, D_DATA} dec_state_t;

  dec_state_t  d_state_reg, d_state_next;
  logic [7:0]  d_sr_reg, d_sr_next;
  logic [1:0]  d_cnt_reg, d_cnt_next;
  logic        pend_valid_reg, pend_valid_next;
  logic [7:0]  pend_byte_reg, pend_byte_next;
  logic        m_valid_reg, m_valid_next;
  logic [7:0]  m_data_reg, m_data_next;
  logic        m_last_reg, m_last_next;
  logic        m_err_reg, m_err_next;
  logic [15:0] dec_frames_reg, dec_frames_next;
  logic [7:0]  sr_shift;

  assign sr_shift = {bus.rmii_txd, d_sr_reg[7:2]};

  always_ff @(posedge rmii_refclk or negedge rstn) begin
    if (!rstn) begin
      d_state_reg    <= D_IDLE;
      d_sr_reg       <= 8'h00;
      d_cnt_reg      <= 2'd0;
      pend_valid_reg <= 1'b0;
      pend_byte_reg  <= 8'h00;
      m_valid_reg    <= 1'b0;
      m_data_reg     <= 8'h00;
      m_last_reg     <= 1'b0;
      m_err_reg      <= 1'b0;
      dec_frames_reg <= 16'h0000;
    end else begin
      d_state_reg    <= d_state_next;
      d_sr_reg       <= d_sr_next;
      d_cnt_reg      <= d_cnt_next;
      pend_valid_reg <= pend_valid_next;
      pend_byte_reg  <= pend_byte_next;
      m_valid_reg    <= m_valid_next;
      m_data_reg     <= m_data_next;
      m_last_reg     <= m_last_next;
      m_err_reg      <= m_err_next;
      dec_frames_reg <= dec_frames_next;
    end
  end

  // A byte is released only once its successor completes, so a truncated
  // trailing byte can still mark its predecessor as last-with-error.
  always_comb begin
    d_state_next    = d_state_reg;
    d_sr_next       = d_sr_reg;
    d_cnt_next      = d_cnt_reg;
    pend_valid_next = pend_valid_reg;
    pend_byte_next  = pend_byte_reg;
    m_valid_next    = 1'b0;
    m_data_next     = m_data_reg;
    m_last_next     = m_last_reg;
    m_err_next      = m_err_reg;
    dec_frames_next = dec_frames_reg;
    case (d_state_reg)
      D_IDLE: begin
        if (bus.rmii_txen) begin
          d_state_next = D_PRE;
          d_sr_next    = {bus.rmii_txd, 6'b000000};
        end
      end
      D_PRE: begin
        if (!bus.rmii_txen) begin
          d_state_next = D_IDLE;
        end else begin
          d_sr_next = sr_shift;
          if (sr_shift == 8'hD5) begin
            d_state_next    = D_DATA;
            d_cnt_next      = 2'd0;
            pend_valid_next = 1'b0;
          end
        end
      end
      D_DATA: begin
        if (bus.rmii_txen) begin
          d_sr_next  = sr_shift;
          d_cnt_next = d_cnt_reg + 2'd1;
          if (d_cnt_reg == 2'd3) begin
            pend_byte_next  = sr_shift;
            pend_valid_next = 1'b1;
            if (pend_valid_reg) begin
              m_valid_next = 1'b1;
              m_data_next  = pend_byte_reg;
              m_last_next  = 1'b0;
              m_err_next   = 1'b0;
            end
          end
        end else begin
          d_state_next    = D_IDLE;
          pend_valid_next = 1'b0;
          if (pend_valid_reg) begin
            m_valid_next    = 1'b1;
            m_data_next     = pend_byte_reg;
            m_last_next     = 1'b1;
            m_err_next      = (d_cnt_reg != 2'd0);
            dec_frames_next = dec_frames_reg + 16'd1;
          end
        end
      end
      default: d_state_next = D_IDLE;
    endcase
  end

  // ---------------- encoder ----------------
  typedef enum logic [1:0] {E_IDLE, E_PRE, E_DATA, E_IFG} enc_state_t;

  enc_state_t  e_state_reg, e_state_next;
  logic [7:0]  e_cnt_reg, e_cnt_next;
  logic [7:0]  e_sh_reg, e_sh_next;
  logic        e_last_reg, e_last_next;
  logic        crsdv_reg, crsdv_next;
  logic [1:0]  rxd_reg, rxd_next;
  logic        underrun_reg, underrun_next;
  logic [15:0] enc_frames_reg, enc_frames_next;
  logic        enc_ready;

  always_ff @(posedge rmii_refclk or negedge rstn) begin
    if (!rstn) begin
      e_state_reg    <= E_IDLE;
      e_cnt_reg      <= 8'd0;
      e_sh_reg       <= 8'h00;
      e_last_reg     <= 1'b0;
      crsdv_reg      <= 1'b0;
      rxd_reg        <= 2'b00;
      underrun_reg   <= 1'b0;
      enc_frames_reg <= 16'h0000;
    end else begin
      e_state_reg    <= e_state_next;
      e_cnt_reg      <= e_cnt_next;
      e_sh_reg       <= e_sh_next;
      e_last_reg     <= e_last_next;
      crsdv_reg      <= crsdv_next;
      rxd_reg        <= rxd_next;
      underrun_reg   <= underrun_next;
      enc_frames_reg <= enc_frames_next;
    end
  end

  // Pin registers are loaded from next-state values so crsdv/rxd line up
  // with the state register; e_cnt indexes the dibit currently on the pins.
  always_comb begin
    e_state_next    = e_state_reg;
    e_cnt_next      = e_cnt_reg;
    e_sh_next       = e_sh_reg;
    e_last_next     = e_last_reg;
    crsdv_next      = 1'b0;
    rxd_next        = 2'b00;
    underrun_next   = 1'b0;
    enc_frames_next = enc_frames_reg;
    enc_ready       = 1'b0;
    case (e_state_reg)
      E_IDLE: begin
        if (bus.s_valid) begin
          e_state_next = E_PRE;
          e_cnt_next   = 8'd0;
          crsdv_next   = 1'b1;
          rxd_next     = 2'b01;
        end
      end
      E_PRE: begin
        if (e_cnt_reg != SFD_IDX) begin
          e_cnt_next = e_cnt_reg + 8'd1;
          crsdv_next = 1'b1;
          rxd_next   = (e_cnt_reg == SFD_IDX - 8'd1) ? 2'b11 : 2'b01;
        end else begin
          enc_ready = 1'b1;
          e_cnt_next = 8'd0;
          if (bus.s_valid) begin
            e_state_next = E_DATA;
            e_sh_next    = bus.s_data;
            e_last_next  = bus.s_last;
            crsdv_next   = 1'b1;
            rxd_next     = bus.s_data[1:0];
          end else begin
            e_state_next  = E_IFG;
            underrun_next = 1'b1;
          end
        end
      end
      E_DATA: begin
        if (e_cnt_reg[1:0] != 2'd3) begin
          e_cnt_next = e_cnt_reg + 8'd1;
          e_sh_next  = {2'b00, e_sh_reg[7:2]};
          crsdv_next = 1'b1;
          rxd_next   = e_sh_reg[3:2];
        end else if (e_last_reg) begin
          e_state_next    = E_IFG;
          e_cnt_next      = 8'd0;
          enc_frames_next = enc_frames_reg + 16'd1;
        end else begin
          enc_ready  = 1'b1;
          e_cnt_next = 8'd0;
          if (bus.s_valid) begin
            e_sh_next   = bus.s_data;
            e_last_next = bus.s_last;
            crsdv_next  = 1'b1;
            rxd_next    = bus.s_data[1:0];
          end else begin
            e_state_next  = E_IFG;
            underrun_next = 1'b1;
          end
        end
      end
      E_IFG: begin
        if (e_cnt_reg == IFG_LAST) begin
          e_state_next = E_IDLE;
        end else begin
          e_cnt_next = e_cnt_reg + 8'd1;
        end
      end
      default: e_state_next = E_IDLE;
    endcase
  end

  assign bus.m_valid    = m_valid_reg;
  assign bus.m_data     = m_data_reg;
  assign bus.m_last     = m_last_reg;
  assign bus.m_err      = m_err_reg;
  assign bus.dec_frames = dec_frames_reg;
  assign bus.rmii_crsdv = crsdv_reg;
  assign bus.rmii_rxd   = rxd_reg;
  assign bus.s_ready    = enc_ready;
  assign bus.underrun   = underrun_reg;
  assign bus.enc_frames = enc_frames_reg;
endmodule
